post_out_writer: RTL and testbench

- Sits directly downstream of the post-processing stage.
- Accepts its POX×16-bit result beats (post_out / post_out_valid) and buffers them in a small FIFO, because that stage has no backpressure.
- Drains the beats to the output feature-map memory through a valid/ready write port.
- Generates channel/row/column addresses and signals completion of a programmed tile.

---
 rtl/post_out_writer_pkg.sv | 18 +
 rtl/post_out_writer_sync_fifo.sv | 61 ++++++
 rtl/post_out_writer.sv | 160 ++++++++++++++++
 tb/tb_post_out_writer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/post_out_writer_pkg.sv
// Shared types and constants for the post-processing output writer.
// The FSM state type lives here so every stage decodes states identically.
package post_out_writer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_POX = 3;
   localparam int BEAT_W  = DEF_POX * 16;

   function automatic int beat_width(input int pox);
      return pox * 16;
   endfunction

endpackage

// File: rtl/post_out_writer_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty/count.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo
   import post_out_writer_pkg::*;
#(
   parameter int W     = BEAT_W,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == {CW{1'b0}});
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {CW{1'b0}};
      end else if (clr) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {CW{1'b0}};
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/post_out_writer.sv
// Buffers post-processing beats and writes them to the output feature-map memory,
// walking channel/row/beat addresses incrementally and flagging tile completion.
module post_out_writer
   import post_out_writer_pkg::*;
#(
   parameter int POX    = DEF_POX,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_W-1:0]   cfg_base,
   input  logic [CNT_W-1:0]    cfg_row_beats,
   input  logic [CNT_W-1:0]    cfg_rows,
   input  logic [CNT_W-1:0]    cfg_channels,
   input  logic [ADDR_W-1:0]   cfg_row_stride,
   input  logic [ADDR_W-1:0]   cfg_ch_stride,
   input  logic [POX*16-1:0]   in_data,
   input  logic                in_valid,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [POX*16-1:0]   wr_data,
   output logic                wr_valid,
   input  logic                wr_ready,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic                stray
);
   localparam int BW = beat_width(POX);

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    row_beats_l, rows_l, channels_l;
   logic [ADDR_W-1:0]   row_stride_l, ch_stride_l;
   logic [CNT_W-1:0]    beat, row, ch;
   logic [ADDR_W-1:0]   ch_base, row_base, addr;
   logic                run, tile_start, zero_cfg, push, pop, drop;
   logic                last_beat, last_row, last_ch;
   logic                fifo_full, fifo_empty;
   logic [BW-1:0]       fifo_head;
   logic [$clog2(DEPTH):0] fifo_count_unused;

   assign run        = (state == ST_RUN);
   assign tile_start = (state == ST_IDLE) && start;
   assign zero_cfg   = (cfg_row_beats == {CNT_W{1'b0}}) || (cfg_rows == {CNT_W{1'b0}}) ||
                       (cfg_channels == {CNT_W{1'b0}});
   assign push       = run && in_valid;
   assign pop        = wr_valid && wr_ready;
   assign drop       = push && fifo_full && !pop;
   assign last_beat  = (beat == row_beats_l - CNT_W'(1));
   assign last_row   = (row == rows_l - CNT_W'(1));
   assign last_ch    = (ch == channels_l - CNT_W'(1));

   assign wr_valid = run && !fifo_empty;
   assign wr_data  = wr_valid ? fifo_head : {BW{1'b0}};
   assign wr_addr  = addr;
   assign busy     = run;
   assign done     = (state == ST_DONE);

   // Flushed on start so over-run beats from a previous tile never leak into the next
   sync_fifo #(.W(BW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (tile_start),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count_unused)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = zero_cfg ? ST_DONE : ST_RUN;
            else       state_nxt = ST_IDLE;
         end
         ST_RUN: begin
            if (pop && last_beat && last_row && last_ch) state_nxt = ST_DONE;
            else                                         state_nxt = ST_RUN;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Configuration latch and incremental address walk (no multipliers)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_beats_l  <= {CNT_W{1'b0}};
         rows_l       <= {CNT_W{1'b0}};
         channels_l   <= {CNT_W{1'b0}};
         row_stride_l <= {ADDR_W{1'b0}};
         ch_stride_l  <= {ADDR_W{1'b0}};
         beat         <= {CNT_W{1'b0}};
         row          <= {CNT_W{1'b0}};
         ch           <= {CNT_W{1'b0}};
         ch_base      <= {ADDR_W{1'b0}};
         row_base     <= {ADDR_W{1'b0}};
         addr         <= {ADDR_W{1'b0}};
      end else if (tile_start) begin
         row_beats_l  <= cfg_row_beats;
         rows_l       <= cfg_rows;
         channels_l   <= cfg_channels;
         row_stride_l <= cfg_row_stride;
         ch_stride_l  <= cfg_ch_stride;
         beat         <= {CNT_W{1'b0}};
         row          <= {CNT_W{1'b0}};
         ch           <= {CNT_W{1'b0}};
         ch_base      <= cfg_base;
         row_base     <= cfg_base;
         addr         <= cfg_base;
      end else if (pop) begin
         if (last_beat) begin
            beat <= {CNT_W{1'b0}};
            if (last_row) begin
               row      <= {CNT_W{1'b0}};
               ch       <= ch + CNT_W'(1);
               ch_base  <= ch_base + ch_stride_l;
               row_base <= ch_base + ch_stride_l;
               addr     <= ch_base + ch_stride_l;
            end else begin
               row      <= row + CNT_W'(1);
               row_base <= row_base + row_stride_l;
               addr     <= row_base + row_stride_l;
            end
         end else begin
            beat <= beat + CNT_W'(1);
            addr <= addr + ADDR_W'(1);
         end
      end
   end

   // Sticky error flags, cleared when a new tile is started
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
         stray    <= 1'b0;
      end else if (tile_start) begin
         overflow <= 1'b0;
         stray    <= 1'b0;
      end else begin
         if (drop)               overflow <= 1'b1;
         if (in_valid && !run)   stray    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_post_out_writer.sv
// Self-checking bench for post_out_writer: table-driven tiles, hand-written
// corner sequences and randomized tiles against a queue-based reference model.
module tb_post_out_writer;
   localparam int AW = 16, CW = 10, BW = 48, DEPTH = 8;

   logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [AW-1:0] cfg_base = '0, cfg_row_stride = '0, cfg_ch_stride = '0;
   logic [CW-1:0] cfg_row_beats = '0, cfg_rows = '0, cfg_channels = '0;
   logic [BW-1:0] in_data = '0;
   logic          in_valid = 1'b0, wr_ready = 1'b0;
   logic [AW-1:0] wr_addr;
   logic [BW-1:0] wr_data;
   logic          wr_valid, busy, done, overflow, stray;

   int n_checks = 0;
   int n_fail   = 0;

   post_out_writer #(.POX(3), .DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_base(cfg_base), .cfg_row_beats(cfg_row_beats), .cfg_rows(cfg_rows),
      .cfg_channels(cfg_channels), .cfg_row_stride(cfg_row_stride), .cfg_ch_stride(cfg_ch_stride),
      .in_data(in_data), .in_valid(in_valid),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .busy(busy), .done(done), .overflow(overflow), .stray(stray)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0]       base;
      logic [9:0]        rb, rows, chs;
      logic [15:0]       rs, cs;
      logic [3:0][15:0]  exp;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [47:0] beat_val(input int i);
      return 48'hBEEF_0000_0000 | 48'(i);
   endfunction

   task automatic start_tile(input logic [15:0] base, input logic [9:0] rb, input logic [9:0] rows,
                             input logic [9:0] chs, input logic [15:0] rs, input logic [15:0] cs);
      cfg_base = base; cfg_row_beats = rb; cfg_rows = rows; cfg_channels = chs;
      cfg_row_stride = rs; cfg_ch_stride = cs;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Four back-to-back beats with wr_ready high; each write one cycle after its beat
   task automatic run_basic(input vec_t v, input int tag);
      start_tile(v.base, v.rb, v.rows, v.chs, v.rs, v.cs);
      wr_ready = 1'b1;
      in_valid = 1'b1;
      in_data  = beat_val(tag * 16);
      for (int i = 0; i < 4; i++) begin
         step();
         if (i < 3) in_data = beat_val(tag * 16 + i + 1);
         else       in_valid = 1'b0;
         @(negedge clk);
         chk("vec wr_valid", 64'(wr_valid), 64'd1);
         chk("vec wr_addr", 64'(wr_addr), 64'(v.exp[i]));
         chk("vec wr_data", 64'(wr_data), 64'(beat_val(tag * 16 + i)));
         chk("vec done early", 64'(done), 64'd0);
      end
      step();
      @(negedge clk);
      chk("vec done", 64'(done), 64'd1);
      chk("vec busy after", 64'(busy), 64'd0);
      chk("vec wr_valid after", 64'(wr_valid), 64'd0);
      chk("vec overflow", 64'(overflow), 64'd0);
      step();
      @(negedge clk);
      chk("vec done pulse", 64'(done), 64'd0);
   endtask

   // Randomized tile checked against a queue model and a multiply-based address list
   task automatic rand_tile();
      logic [15:0] base, rs, cs;
      int          rb, rows, chs, total, widx, accepted, cyc;
      logic [15:0] ea [$];
      logic [47:0] q [$];
      logic [47:0] d;
      logic        ovf, iv, ev, pop;
      base = 16'($urandom()); rs = 16'($urandom()); cs = 16'($urandom());
      rb = $urandom_range(1, 4); rows = $urandom_range(1, 3); chs = $urandom_range(1, 3);
      total = rb * rows * chs;
      for (int c = 0; c < chs; c++)
         for (int r = 0; r < rows; r++)
            for (int b = 0; b < rb; b++)
               ea.push_back(16'(int'(base) + c * int'(cs) + r * int'(rs) + b));
      widx = 0; accepted = 0; ovf = 1'b0; cyc = 0;
      start_tile(base, 10'(rb), 10'(rows), 10'(chs), rs, cs);
      while (widx < total && cyc < 2000) begin
         iv = (accepted < total) && ($urandom_range(0, 1) == 1);
         d  = {16'($urandom()), $urandom()};
         in_valid = iv; in_data = d;
         wr_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         ev = (q.size() > 0);
         chk("rand wr_valid", 64'(wr_valid), 64'(ev));
         if (ev) begin
            chk("rand wr_data", 64'(wr_data), 64'(q[0]));
            chk("rand wr_addr", 64'(wr_addr), 64'(ea[widx]));
         end
         chk("rand overflow", 64'(overflow), 64'(ovf));
         chk("rand busy", 64'(busy), 64'd1);
         pop = ev && wr_ready;
         if (iv) begin
            if (q.size() < DEPTH || pop) begin
               q.push_back(d);
               accepted++;
            end else begin
               ovf = 1'b1;
            end
         end
         if (pop) begin
            void'(q.pop_front());
            widx++;
         end
         step();
         cyc++;
      end
      in_valid = 1'b0;
      chk("rand tile complete", 64'(widx), 64'(total));
      @(negedge clk);
      chk("rand done", 64'(done), 64'd1);
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{16'h0100, 10'd2, 10'd2, 10'd1, 16'h0010, 16'h0000,
                  {16'h0111, 16'h0110, 16'h0101, 16'h0100}};
      vecs[1] = '{16'h0000, 10'd1, 10'd2, 10'd2, 16'h0004, 16'h0040,
                  {16'h0044, 16'h0040, 16'h0004, 16'h0000}};
      vecs[2] = '{16'hFFFE, 10'd2, 10'd1, 10'd2, 16'h0010, 16'h0001,
                  {16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFE}};
      vecs[3] = '{16'h0020, 10'd4, 10'd1, 10'd1, 16'h0000, 16'h0000,
                  {16'h0023, 16'h0022, 16'h0021, 16'h0020}};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset wr_valid", 64'(wr_valid), 64'd0);
      chk("reset wr_addr", 64'(wr_addr), 64'd0);
      chk("reset wr_data", 64'(wr_data), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset flags", 64'({overflow, stray}), 64'd0);
      rst = 1'b1;
      step();

      for (int v = 0; v < 4; v++) run_basic(vecs[v], v);

      // Backpressure: 8 beats fill the FIFO under a 20-cycle stall, 9th is dropped
      start_tile(16'h0200, 10'd8, 10'd1, 10'd1, 16'h0010, 16'h0000);
      wr_ready = 1'b0;
      for (int c = 0; c < 20; c++) begin
         in_valid = (c < 8) || (c == 12);
         in_data  = (c == 12) ? beat_val(99) : beat_val(32 + c);
         step();
         in_valid = 1'b0;
         @(negedge clk);
         chk("stall wr_valid", 64'(wr_valid), 64'd1);
         chk("stall wr_addr", 64'(wr_addr), 64'h200);
         chk("stall wr_data", 64'(wr_data), 64'(beat_val(32)));
         chk("stall overflow", 64'(overflow), 64'(c >= 12));
      end
      wr_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain wr_valid", 64'(wr_valid), 64'd1);
         chk("drain wr_addr", 64'(wr_addr), 64'(16'h200 + 16'(i)));
         chk("drain wr_data", 64'(wr_data), 64'(beat_val(32 + i)));
         step();
         @(negedge clk);
      end
      chk("drain done", 64'(done), 64'd1);
      chk("drain wr_valid after", 64'(wr_valid), 64'd0);
      step();

      // Full FIFO with simultaneous push and pop keeps occupancy at DEPTH
      start_tile(16'h0400, 10'd9, 10'd1, 10'd1, 16'h0000, 16'h0000);
      wr_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         in_valid = 1'b1;
         in_data  = beat_val(64 + c);
         step();
      end
      in_data = beat_val(72); wr_ready = 1'b1;
      step();
      in_valid = 1'b0; wr_ready = 1'b0;
      @(negedge clk);
      chk("fullpop overflow", 64'(overflow), 64'd0);
      chk("fullpop wr_addr", 64'(wr_addr), 64'h401);
      chk("fullpop wr_data", 64'(wr_data), 64'(beat_val(65)));
      in_valid = 1'b1; in_data = beat_val(99);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("fullpop still full", 64'(overflow), 64'd1);
      wr_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk("fullpop drain addr", 64'(wr_addr), 64'(16'h400 + 16'(i)));
         chk("fullpop drain data", 64'(wr_data), 64'(beat_val(64 + i)));
         step();
         @(negedge clk);
      end
      chk("fullpop done", 64'(done), 64'd1);
      step();

      // Zero configuration goes straight to DONE; input in IDLE is stray
      wr_ready = 1'b1;
      start_tile(16'h0500, 10'd4, 10'd0, 10'd2, 16'h0000, 16'h0000);
      @(negedge clk);
      chk("zero done", 64'(done), 64'd1);
      chk("zero busy", 64'(busy), 64'd0);
      chk("zero wr_valid", 64'(wr_valid), 64'd0);
      step();
      @(negedge clk);
      chk("zero done pulse", 64'(done), 64'd0);
      chk("zero busy idle", 64'(busy), 64'd0);
      chk("zero stray clear", 64'(stray), 64'd0);
      in_valid = 1'b1; in_data = beat_val(7);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("idle stray", 64'(stray), 64'd1);
      chk("idle wr_valid", 64'(wr_valid), 64'd0);

      // Asynchronous reset in the middle of a stalled tile
      start_tile(16'h0300, 10'd4, 10'd1, 10'd1, 16'h0000, 16'h0000);
      wr_ready = 1'b0;
      @(negedge clk);
      chk("start clears stray", 64'(stray), 64'd0);
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1; in_data = beat_val(80 + c);
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre-reset wr_valid", 64'(wr_valid), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("async wr_valid", 64'(wr_valid), 64'd0);
      chk("async wr_addr", 64'(wr_addr), 64'd0);
      chk("async wr_data", 64'(wr_data), 64'd0);
      chk("async busy", 64'(busy), 64'd0);
      chk("async done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("post-reset empty", 64'(wr_valid), 64'd0);
      run_basic(vecs[0], 5);

      // Randomized tiles
      for (int t = 0; t < 8; t++) rand_tile();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
